// File: rtl/riscv_memsplit.sv
// Splits byte/halfword/word accesses that straddle a 32-bit word boundary into
// two word-aligned downstream beats and reassembles load data.
package riscv_memsplit_pkg;
    typedef enum logic [2:0] {
        BYTE  = 3'd0,
        HWORD = 3'd1,
        WORD  = 3'd2,
        DWORD = 3'd3
    } biu_size_t;
endpackage

// state | meaning
// IDLE  | waiting for req_i, not busy
// BEAT0 | first (or only) downstream word beat outstanding
// BEAT1 | second word beat of a misaligned access outstanding
// DONE  | one-cycle ack_o / err_o pulse
module riscv_memsplit
    import riscv_memsplit_pkg::*;
#(
    parameter int PLEN = 32,
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_i,
    input  logic [PLEN-1:0] adr_i,
    input  biu_size_t       size_i,
    input  logic            we_i,
    input  logic [XLEN-1:0] d_i,
    output logic            busy_o,
    output logic            ack_o,
    output logic            err_o,
    output logic [XLEN-1:0] q_o,
    output logic            mem_req_o,
    output logic [PLEN-1:0] mem_adr_o,
    output logic            mem_we_o,
    output logic [3:0]      mem_be_o,
    output logic [XLEN-1:0] mem_d_o,
    input  logic            mem_ack_i,
    input  logic            mem_err_i,
    input  logic [XLEN-1:0] mem_q_i
);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

    state_t          state_q, state_d;
    logic            busy_q, busy_d;
    logic            ack_q, ack_d;
    logic            err_q, err_d;
    logic            mem_req_q, mem_req_d;
    logic [PLEN-1:0] mem_adr_q, mem_adr_d;
    logic            mem_we_q, mem_we_d;
    logic [3:0]      mem_be_q, mem_be_d;
    logic [XLEN-1:0] mem_d_q, mem_d_d;
    logic [PLEN-1:0] adr_q, adr_d;
    biu_size_t       size_q, size_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] d_q, d_d;
    logic [XLEN-1:0] ld_q, ld_d;
    logic [XLEN-1:0] q_q, q_d;

    logic [1:0]      off_r;
    logic [2:0]      n_r;
    logic [3:0]      end_r;
    logic            split_r;

    // Zero marks a size the splitter cannot serve (DWORD or unused encodings).
    function automatic logic [2:0] size_bytes(input biu_size_t s);
        case (s)
            BYTE:    return 3'd1;
            HWORD:   return 3'd2;
            WORD:    return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [3:0] lanes(input logic [2:0] n, input logic [1:0] off,
                                         input logic second);
        logic [3:0] ones;
        case (n)
            3'd1:    ones = 4'b0001;
            3'd2:    ones = 4'b0011;
            default: ones = 4'b1111;
        endcase
        if (second) return ones >> (3'd4 - {1'b0, off});
        else        return ones << off;
    endfunction

    function automatic logic [XLEN-1:0] byte_mask(input logic [2:0] n);
        case (n)
            3'd1:    return {{(XLEN-8){1'b0}}, 8'hFF};
            3'd2:    return {{(XLEN-16){1'b0}}, 16'hFFFF};
            default: return '1;
        endcase
    endfunction

    function automatic logic [4:0] sh_lo(input logic [1:0] off);
        return {off, 3'b000};
    endfunction

    function automatic logic [5:0] sh_hi(input logic [1:0] off);
        return {3'd4 - {1'b0, off}, 3'b000};
    endfunction

    assign off_r   = adr_q[1:0];
    assign n_r     = size_bytes(size_q);
    assign end_r   = {2'b00, off_r} + {1'b0, n_r};
    assign split_r = end_r > 4'd4;

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        mem_req_d = mem_req_q;
        mem_adr_d = mem_adr_q;
        mem_we_d  = mem_we_q;
        mem_be_d  = mem_be_q;
        mem_d_d   = mem_d_q;
        adr_d     = adr_q;
        size_d    = size_q;
        we_d      = we_q;
        d_d       = d_q;
        ld_d      = ld_q;
        q_d       = q_q;

        case (state_q)
            IDLE: begin
                if (req_i) begin
                    adr_d  = adr_i;
                    size_d = size_i;
                    we_d   = we_i;
                    d_d    = d_i;
                    busy_d = 1'b1;
                    if (size_bytes(size_i) == 3'd0) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d   = BEAT0;
                        mem_req_d = 1'b1;
                        mem_adr_d = {adr_i[PLEN-1:2], 2'b00};
                        mem_be_d  = lanes(size_bytes(size_i), adr_i[1:0], 1'b0);
                        mem_we_d  = we_i;
                        mem_d_d   = d_i << sh_lo(adr_i[1:0]);
                    end
                end
            end
            BEAT0: begin
                if (mem_err_i) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                end else if (mem_ack_i) begin
                    ld_d = mem_q_i >> sh_lo(off_r);
                    if (split_r) begin
                        state_d   = BEAT1;
                        mem_adr_d = {adr_q[PLEN-1:2], 2'b00} + PLEN'(4);
                        mem_be_d  = lanes(n_r, off_r, 1'b1);
                        mem_d_d   = d_q >> sh_hi(off_r);
                    end else begin
                        state_d   = DONE;
                        mem_req_d = 1'b0;
                        ack_d     = 1'b1;
                        if (!we_q) q_d = (mem_q_i >> sh_lo(off_r)) & byte_mask(n_r);
                    end
                end
            end
            BEAT1: begin
                if (mem_err_i) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                end else if (mem_ack_i) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    ack_d     = 1'b1;
                    if (!we_q) q_d = (ld_q | (mem_q_i << sh_hi(off_r))) & byte_mask(n_r);
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            mem_req_q <= 1'b0;
            mem_adr_q <= '0;
            mem_we_q  <= 1'b0;
            mem_be_q  <= '0;
            mem_d_q   <= '0;
            adr_q     <= '0;
            size_q    <= BYTE;
            we_q      <= 1'b0;
            d_q       <= '0;
            ld_q      <= '0;
            q_q       <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            mem_req_q <= mem_req_d;
            mem_adr_q <= mem_adr_d;
            mem_we_q  <= mem_we_d;
            mem_be_q  <= mem_be_d;
            mem_d_q   <= mem_d_d;
            adr_q     <= adr_d;
            size_q    <= size_d;
            we_q      <= we_d;
            d_q       <= d_d;
            ld_q      <= ld_d;
            q_q       <= q_d;
        end
    end

    assign busy_o    = busy_q;
    assign ack_o     = ack_q;
    assign err_o     = err_q;
    assign q_o       = q_q;
    assign mem_req_o = mem_req_q;
    assign mem_adr_o = mem_adr_q;
    assign mem_we_o  = mem_we_q;
    assign mem_be_o  = mem_be_q;
    assign mem_d_o   = mem_d_q;

endmodule

// File: tb/tb_riscv_memsplit.sv
// Bench for riscv_memsplit: directed cases plus random accesses checked against
// a byte-addressed model of which memory bytes each access touches.
module tb_riscv_memsplit;
    import riscv_memsplit_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic [31:0] adr_i;
    biu_size_t   size_i;
    logic        we_i;
    logic [31:0] d_i;
    logic        busy_o, ack_o, err_o;
    logic [31:0] q_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_adr_o, mem_d_o;
    logic [3:0]  mem_be_o;
    logic        mem_ack_i, mem_err_i;
    logic [31:0] mem_q_i;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] last_q;
    logic [31:0] mem_ov [logic [31:0]];

    riscv_memsplit #(.PLEN(32), .XLEN(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .adr_i(adr_i), .size_i(size_i),
        .we_i(we_i), .d_i(d_i), .busy_o(busy_o), .ack_o(ack_o), .err_o(err_o), .q_o(q_o),
        .mem_req_o(mem_req_o), .mem_adr_o(mem_adr_o), .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o), .mem_d_o(mem_d_o), .mem_ack_i(mem_ack_i),
        .mem_err_i(mem_err_i), .mem_q_i(mem_q_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        chk(tag, {31'b0, got}, {31'b0, exp});
    endtask

    function automatic logic [31:0] rd_word(input logic [31:0] w);
        if (mem_ov.exists(w)) return mem_ov[w];
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk_quiet(input string tag);
        chk1({tag, "_busy"}, busy_o, 1'b0);
        chk1({tag, "_ack"}, ack_o, 1'b0);
        chk1({tag, "_err"}, err_o, 1'b0);
        chk1({tag, "_mreq"}, mem_req_o, 1'b0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk_quiet(tag);
        chk({tag, "_q"}, q_o, 32'h0);
        chk({tag, "_madr"}, mem_adr_o, 32'h0);
        chk({tag, "_mbe"}, {28'b0, mem_be_o}, 32'h0);
        chk({tag, "_md"}, mem_d_o, 32'h0);
    endtask

    // err_beat: beat index that answers with mem_err_i (-1 for none);
    // both: also raise mem_ack_i alongside the error.
    task automatic do_txn(input logic [31:0] a, input logic [2:0] sz, input logic we,
                          input logic [31:0] d, input int err_beat, input bit both,
                          input int max_wait);
        logic [31:0] wa [2];
        logic [3:0]  be_m [2];
        logic [31:0] dat_m [2];
        logic [31:0] q_exp, ba, wd;
        int          n, nb, b, idx, w;
        bit          legal, stop;

        legal = (sz < 3'd3);
        n = (sz == 3'd0) ? 1 : (sz == 3'd1) ? 2 : 4;
        wa[0] = {a[31:2], 2'b00};
        wa[1] = wa[0] + 32'd4;
        be_m[0] = '0; be_m[1] = '0; dat_m[0] = '0; dat_m[1] = '0;
        q_exp = '0;
        nb = 1;
        for (int k = 0; k < n; k++) begin
            ba = a + 32'(k);
            b  = ({ba[31:2], 2'b00} == wa[0]) ? 0 : 1;
            if (b == 1) nb = 2;
            be_m[b][ba[1:0]] = 1'b1;
            wd = rd_word({ba[31:2], 2'b00});
            q_exp[8*k +: 8] = wd[8*ba[1:0] +: 8];
        end
        for (int bb = 0; bb < 2; bb++)
            for (int j = 0; j < 4; j++) begin
                idx = 4*bb + j - int'(a[1:0]);
                if (idx >= 0 && idx < 4) dat_m[bb][8*j +: 8] = d[8*idx +: 8];
            end

        @(negedge clk_i);
        chk_quiet("pre");
        chk("pre_q", q_o, last_q);
        req_i = 1'b1; adr_i = a; size_i = biu_size_t'(sz); we_i = we; d_i = d;
        mem_ack_i = 1'b0; mem_err_i = 1'b0;

        if (!legal) begin
            @(negedge clk_i);
            req_i = 1'($urandom_range(0, 1)); adr_i = $urandom;
            chk1("sz_err", err_o, 1'b1);
            chk1("sz_ack", ack_o, 1'b0);
            chk1("sz_mreq", mem_req_o, 1'b0);
            chk1("sz_busy", busy_o, 1'b1);
            chk("sz_q", q_o, last_q);
            return;
        end

        stop = 1'b0;
        for (b = 0; b < nb && !stop; b++) begin
            w = int'($urandom_range(0, max_wait));
            for (int c = 0; c <= w; c++) begin
                @(negedge clk_i);
                req_i = 1'($urandom_range(0, 1)); adr_i = $urandom; d_i = $urandom;
                we_i = 1'($urandom_range(0, 1)); size_i = biu_size_t'(3'($urandom_range(0, 7)));
                chk1("beat_req", mem_req_o, 1'b1);
                chk("beat_adr", mem_adr_o, wa[b]);
                chk("beat_be", {28'b0, mem_be_o}, {28'b0, be_m[b]});
                chk1("beat_we", mem_we_o, we);
                if (we) chk("beat_d", mem_d_o, dat_m[b]);
                chk1("beat_busy", busy_o, 1'b1);
                chk1("beat_ack", ack_o, 1'b0);
                chk1("beat_err", err_o, 1'b0);
                mem_q_i = $urandom;
                if (c == w) begin
                    if (err_beat == b) begin
                        mem_err_i = 1'b1; mem_ack_i = both; stop = 1'b1;
                    end else begin
                        mem_ack_i = 1'b1; mem_err_i = 1'b0; mem_q_i = rd_word(wa[b]);
                    end
                end else begin
                    mem_ack_i = 1'b0; mem_err_i = 1'b0;
                end
            end
        end

        @(negedge clk_i);
        mem_ack_i = 1'b0; mem_err_i = 1'b0; req_i = 1'($urandom_range(0, 1));
        chk1("done_ack", ack_o, !stop);
        chk1("done_err", err_o, stop);
        chk1("done_mreq", mem_req_o, 1'b0);
        chk1("done_busy", busy_o, 1'b1);
        if (!stop && !we) last_q = q_exp;
        chk("done_q", q_o, last_q);
    endtask

    task automatic idle_gap(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk_i);
            chk_quiet("gap");
            chk("gap_q", q_o, last_q);
            req_i = 1'b0;
            mem_ack_i = 1'($urandom_range(0, 1));
            mem_q_i = $urandom;
        end
    endtask

    initial begin
        logic [31:0] a, d;
        logic [2:0]  sz;
        int          eb;

        rst_i = 1'b1; req_i = 1'b0; adr_i = '0; size_i = BYTE; we_i = 1'b0; d_i = '0;
        mem_ack_i = 1'b0; mem_err_i = 1'b0; mem_q_i = '0;
        mem_ov[32'h3000] = 32'hCAFE_F00D;
        mem_ov[32'h1000] = 32'h4433_2211;
        mem_ov[32'h1004] = 32'h8877_6655;
        repeat (3) @(negedge clk_i);
        chk_reset_outputs("rst");
        rst_i = 1'b0;
        last_q = '0;

        do_txn(32'h0000_3000, 3'd2, 1'b0, 32'h0, -1, 1'b0, 0);
        chk("dir_aligned_q", q_o, 32'hCAFE_F00D);
        do_txn(32'h0000_1001, 3'd2, 1'b0, 32'h0, -1, 1'b0, 0);
        chk("dir_split_q", q_o, 32'h5544_3322);
        do_txn(32'h0000_2003, 3'd1, 1'b1, 32'h0000_BEEF, -1, 1'b0, 0);
        do_txn(32'h0000_1002, 3'd2, 1'b0, 32'h0, 0, 1'b0, 0);
        do_txn(32'h0000_0040, 3'd3, 1'b0, 32'h0, -1, 1'b0, 0);
        do_txn(32'h0000_1001, 3'd2, 1'b0, 32'h0, 1, 1'b1, 1);
        idle_gap(2);

        for (int t = 0; t < 300; t++) begin
            a = $urandom;
            if ($urandom_range(0, 7) == 0) a[31:2] = '1;
            sz = 3'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) sz = 3'($urandom_range(3, 7));
            d = $urandom;
            eb = -1;
            if ($urandom_range(0, 7) == 0) eb = int'($urandom_range(0, 1));
            do_txn(a, sz, 1'($urandom_range(0, 1)), d, eb, 1'($urandom_range(0, 1)), 2);
            if ($urandom_range(0, 3) == 0) idle_gap(int'($urandom_range(1, 3)));
        end

        // Wrap at top of memory, then reset while BEAT1 is outstanding.
        @(negedge clk_i);
        req_i = 1'b1; adr_i = 32'hFFFF_FFFF; size_i = HWORD; we_i = 1'b0;
        mem_ack_i = 1'b0; mem_err_i = 1'b0;
        @(negedge clk_i);
        req_i = 1'b0;
        chk("wrap_b0_adr", mem_adr_o, 32'hFFFF_FFFC);
        chk("wrap_b0_be", {28'b0, mem_be_o}, 32'h8);
        mem_ack_i = 1'b1; mem_q_i = rd_word(32'hFFFF_FFFC);
        @(negedge clk_i);
        chk1("wrap_b1_req", mem_req_o, 1'b1);
        chk("wrap_b1_adr", mem_adr_o, 32'h0000_0000);
        chk("wrap_b1_be", {28'b0, mem_be_o}, 32'h1);
        mem_ack_i = 1'b0; rst_i = 1'b1;
        @(negedge clk_i);
        chk_reset_outputs("mid_rst");
        mem_ack_i = 1'b1;
        @(negedge clk_i);
        chk_reset_outputs("mid_rst2");
        rst_i = 1'b0;
        @(negedge clk_i);
        chk_reset_outputs("late_ack");
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        chk_reset_outputs("post_rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
